// File: rtl/heartbeat_sampler.sv
// heartbeat_sampler: synchronizes and qualifies the raw pulse-sensor input,
// measures the inter-beat interval in milliseconds, packs each beat (or an
// outage) into a 32-bit record and hands it to the peripheral over a
// 4-phase IO_READ_RDY / IO_READ_ACK handshake with a one-entry pending buffer.
module heartbeat_sampler #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned REFRACT_MS = 250,
    parameter int unsigned TIMEOUT_MS = 3000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        BEAT_IN,
    input  logic        IO_READ_ACK,
    output logic [31:0] IO_HEARTBEAT,
    output logic        IO_READ_RDY
);

    // Millisecond prescaler geometry; a divisor below 1 is clamped to 1.
    localparam int unsigned TICK_DIV  = (CLK_HZ / 1000 >= 1) ? CLK_HZ / 1000 : 1;
    localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [15:0]   REFRACT   = 16'(REFRACT_MS);
    localparam logic [15:0]   TIMEOUT   = 16'(TIMEOUT_MS);
    localparam logic [15:0]   MS_MAX    = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Input synchronizer and edge-detect history.
    logic sync1_q, sync2_q, sync_prev_q;

    // Measurement state.
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   ms_cnt_q, ms_cnt_d;
    logic [7:0]    seq_q, seq_d;
    logic          first_q, first_d;     // next accepted beat waives refractory, interval 0
    logic          armed_q, armed_d;     // a timeout record may still be emitted for this outage

    // Pending buffer and handshake.
    logic          pend_full_q, pend_full_d;
    logic [31:0]   pend_data_q, pend_data_d;
    logic [31:0]   hb_q, hb_d;
    state_e        state_q, state_d;

    // Combinational events.
    logic          rise, tick, accept, tmo, new_rec, unload, overrun;
    logic [15:0]   interval;

    // Two-flop synchronizer on BEAT_IN plus one history flop for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync_prev_q <= 1'b0;
        end else begin
            sync1_q     <= BEAT_IN;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
        end
    end

    assign rise = sync2_q & ~sync_prev_q;
    assign tick = (presc_q == PRESC_MAX);

    // Handshake FSM: unload pending into the output register, hold it while
    // valid, then wait for the ACK level to return low.
    // NOTE: every output of an always_comb gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        hb_d    = hb_q;
        unload  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_full_q && !IO_READ_ACK) begin
                    unload  = 1'b1;
                    hb_d    = pend_data_q;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (IO_READ_ACK) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!IO_READ_ACK) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat qualification, interval/timeout bookkeeping and pending-buffer writes.
    always_comb begin
        // An accepted beat outranks a timeout reached in the same cycle.
        accept   = rise & (first_q | (ms_cnt_q >= REFRACT));
        tmo      = armed_q & (ms_cnt_q >= TIMEOUT) & ~accept;
        new_rec  = accept | tmo;
        // A full pending entry being unloaded this cycle is not lost.
        overrun  = pend_full_q & ~unload;
        interval = tmo ? MS_MAX : (first_q ? 16'h0000 : ms_cnt_q);

        presc_d  = tick ? '0 : presc_q + PW'(1);

        ms_cnt_d = ms_cnt_q;
        if (accept) begin
            ms_cnt_d = 16'h0000;               // a coincident tick is dropped
        end else if (tick && ms_cnt_q != MS_MAX) begin
            ms_cnt_d = ms_cnt_q + 16'd1;
        end

        seq_d   = new_rec ? seq_q + 8'd1 : seq_q;
        first_d = first_q;
        armed_d = armed_q;
        if (accept) begin
            first_d = 1'b0;
            armed_d = 1'b1;
        end else if (tmo) begin
            first_d = 1'b1;
            armed_d = 1'b0;
        end

        pend_full_d = pend_full_q;
        pend_data_d = pend_data_q;
        if (new_rec) begin
            pend_full_d = 1'b1;
            pend_data_d = {6'b0, tmo, overrun, seq_q, interval};
        end else if (unload) begin
            pend_full_d = 1'b0;
        end
    end

    // Measurement and pending-buffer registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            presc_q     <= '0;
            ms_cnt_q    <= 16'h0000;
            seq_q       <= 8'h00;
            first_q     <= 1'b1;
            armed_q     <= 1'b1;
            pend_full_q <= 1'b0;
            pend_data_q <= 32'h0;
        end else begin
            presc_q     <= presc_d;
            ms_cnt_q    <= ms_cnt_d;
            seq_q       <= seq_d;
            first_q     <= first_d;
            armed_q     <= armed_d;
            pend_full_q <= pend_full_d;
            pend_data_q <= pend_data_d;
        end
    end

    // Handshake state and output record register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            hb_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            hb_q    <= hb_d;
        end
    end

    assign IO_HEARTBEAT = hb_q;
    assign IO_READ_RDY  = (state_q == ST_VALID);

endmodule
